// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB register slave: bus widths,
//               the read-only ID value and the 2-bit FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 8;

  // Value returned by the read-only register at the top of the address map.
  localparam logic [APB_DATA_W-1:0] ID_VALUE = 8'hA5;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/apb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_if
// Description : APB3-style bus bundle between one master and one slave.
// Ports       : psel, penable, pwrite, paddr, pwdata  (master -> slave)
//               prdata, pready, pslverr               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_slave_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : DEPTH x 8-bit register storage with one synchronous write
//               port and one combinational read port. Cleared by reset.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               we, waddr,
//               wdata          - write port (commits on rising edge)
//               raddr, rdata   - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  we,
  input  wire logic [IDX_W-1:0]      waddr,
  input  wire logic [APB_DATA_W-1:0] wdata,
  input  wire logic [IDX_W-1:0]      raddr,
  output logic      [APB_DATA_W-1:0] rdata
);

  // One bit wider than the index so DEPTH itself is representable.
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Guard keeps a non-power-of-two DEPTH from reading past the array.
  assign rdata = ({1'b0, raddr} < DEPTH_LIM) ? mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave
// Description : APB register slave with a programmable number of wait
//               states. DEPTH 8-bit registers; the top address is a
//               read-only ID register. Out-of-range accesses return an error.
// Ports       : clk  - clock, all state updates on the rising edge
//               rst  - synchronous active-high reset
//               bus  - apb_slave_if.slave (psel, penable, pwrite, paddr,
//                      pwdata in; prdata, pready, pslverr out, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 16
) (
  input  wire logic  clk,
  input  wire logic  rst,
  apb_slave_if.slave bus
);

  localparam int             IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Address comparisons are done on 9 bits so all 8 paddr bits take part
  // in the range check and DEPTH=256 still works.
  localparam logic [8:0]     DEPTH_LIM = 9'(DEPTH);
  localparam logic [8:0]     ID_ADDR   = 9'(DEPTH - 1);
  localparam logic [2:0]     WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0
                                                            : 3'(WAIT_STATES - 1);

  // FSM
  logic [1:0] state;
  logic [1:0] state_next;

  // Wait counter and transfer latches
  logic [2:0]            wait_cnt;
  logic [2:0]            wait_cnt_next;
  logic [APB_ADDR_W-1:0] addr_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic                  write_q;
  logic                  capture;

  // Response registers and their next values
  logic [APB_DATA_W-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [APB_DATA_W-1:0] prdata_d;
  logic                  pready_d;
  logic                  pslverr_d;

  // Address/direction of the transfer being decided this cycle. In IDLE the
  // latches are only loaded on the setup edge, so with zero wait states the
  // response must be computed straight from the bus.
  logic [APB_ADDR_W-1:0] cur_addr;
  logic                  cur_write;
  logic                  addr_ok;
  logic                  addr_is_id;
  logic [APB_DATA_W-1:0] rd_data;
  logic                  commit;

  assign cur_addr   = (state == ST_IDLE) ? bus.paddr  : addr_q;
  assign cur_write  = (state == ST_IDLE) ? bus.pwrite : write_q;
  assign addr_ok    = ({1'b0, cur_addr} < DEPTH_LIM);
  assign addr_is_id = ({1'b0, cur_addr} == ID_ADDR);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        // psel with penable already high is a protocol violation: ignored.
        if (bus.psel && !bus.penable) begin
          state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          state_next = ST_IDLE;
        end else if (bus.penable && (wait_cnt == 3'd0)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath control logic
  // --------------------------------------------------------------------------
  always_comb begin
    capture       = 1'b0;
    wait_cnt_next = wait_cnt;
    commit        = 1'b0;
    pready_d      = 1'b0;
    prdata_d      = '0;
    pslverr_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          capture       = 1'b1;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          wait_cnt_next = 3'd0;
        end else if (bus.penable && (wait_cnt != 3'd0)) begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      ST_RESP: begin
        wait_cnt_next = 3'd0;
        // Writes land only on the completing edge, and only if the master is
        // still in the access phase; the ID register is never written.
        commit = bus.psel && bus.penable && write_q && addr_ok && !addr_is_id;
      end
      default: begin
        wait_cnt_next = 3'd0;
      end
    endcase

    // Response registers are loaded on the edge entering RESP, so pready is
    // high for exactly the RESP cycle and everything is zero otherwise.
    if ((state != ST_RESP) && (state_next == ST_RESP)) begin
      pready_d = 1'b1;
      if (!addr_ok) begin
        pslverr_d = 1'b1;
      end else if (cur_write) begin
        pslverr_d = addr_is_id;
      end else begin
        prdata_d = addr_is_id ? ID_VALUE : rd_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      if (capture) begin
        addr_q  <= bus.paddr;
        wdata_q <= bus.pwdata;
        write_q <= bus.pwrite;
      end
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

  // --------------------------------------------------------------------------
  // Register storage
  // --------------------------------------------------------------------------
  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .raddr (cur_addr[IDX_W-1:0]),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter WAIT_STATES, default 1: the number of pready-low cycles in each access phase (legal range 0..7).
REQ-002 Parameter DEPTH, default 16: the number of 8-bit registers; the decoded address range is 0..DEPTH-1.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 psel  input  1  slave select from the APB master.
REQ-006 penable  input  1  access-phase strobe.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  8  write data.
REQ-010 prdata  output  8  read data, registered.
REQ-011 pready  output  1  transfer-complete strobe, registered.
REQ-012 pslverr  output  1  error response, registered, valid only while pready=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE, on an edge with psel=1 and penable=0 (setup), the block SHALL latch paddr, pwrite and pwdata, then:
- WAIT_STATES=0: go to RESP.
- otherwise: go to WAIT and load the wait counter with WAIT_STATES-1.
REQ-015 In WAIT, the wait counter SHALL decrement on each edge with psel=1 and penable=1; at count 0 the FSM SHALL go to RESP.
REQ-016 pready, prdata and pslverr SHALL be driven from the registers loaded on the edge that enters RESP, so pready=1 exactly during the RESP cycle. The enable phase therefore lasts WAIT_STATES+1 cycles.
REQ-017 A read of an in-range, readable address SHALL return the register contents in prdata with pslverr=0.
REQ-018 A write SHALL commit the latched pwdata to the register file on the RESP edge with psel=1, penable=1 and a legal address; no earlier commit is permitted.
REQ-019 Address DEPTH-1 SHALL be a read-only ID register:
- reads return ID_VALUE (0xA5) with pslverr=0;
- writes are discarded with pslverr=1.
REQ-020 An address >= DEPTH SHALL give pslverr=1 and prdata=0x00, and SHALL leave the register file unchanged.
REQ-021 Whenever pready=0, prdata and pslverr SHALL be 0x00 and 0.
REQ-022 From RESP the FSM SHALL always return to IDLE, so back-to-back transfers need a new setup cycle; a setup on the cycle immediately after RESP SHALL be accepted.
REQ-023 If psel drops while the FSM is in WAIT or RESP, the FSM SHALL return to IDLE with no register write, and pready SHALL be 0 on the next cycle.
REQ-024 In IDLE, psel=1 with penable=1 (no setup seen) is a protocol violation; the block SHALL ignore it and stay in IDLE with pready=0.
REQ-025 The block SHALL ignore changes to paddr, pwrite or pwdata after setup; the latched values govern the whole transfer.
REQ-026 The block SHALL use paddr bits [7:0] in full for range checking, with no aliasing.

Reset
REQ-027 While rst=1, on each clk edge the block SHALL set:
- FSM to IDLE, wait counter to 0;
- pready=0, pslverr=0, prdata=0x00;
- the latched address, data and direction to 0;
- all read/write registers to 0x00.
REQ-028 A reset asserted mid-transfer SHALL abort the transfer with no write; the first setup after rst deasserts SHALL be accepted normally.

Structure
REQ-029 Package apb_pkg SHALL hold:
- the FSM state encoding (2-bit);
- ID_VALUE = 8'hA5;
- the APB data and address widths (8).
REQ-030 The storage SHALL be the sub-module apb_slave_regfile:
- DEPTH x 8 storage;
- one synchronous write port with enable;
- one combinational read port.
The FSM, wait counter and response registers SHALL remain in apb_slave.

Verification
REQ-031 Write then read, WAIT_STATES=1: write 0x3C to address 0x02, then read address 0x02 -> pready high on the second enable cycle of each transfer, prdata=0x3C, pslverr=0.
REQ-032 Zero-wait, WAIT_STATES=0: read address 0x05 after reset -> pready=1 on the first enable cycle, prdata=0x00.
REQ-033 Error cases:
- write 0x77 to address 0x20 -> pslverr=1 with pready, and no register changes;
- read address 0x0F -> prdata=0xA5, pslverr=0;
- write address 0x0F -> pslverr=1.
REQ-034 Abort: with WAIT_STATES=3, deassert psel during the second enable cycle of a write of 0x11 to address 0x01 -> pready never asserts and address 0x01 still reads 0x00.
REQ-035 Back-to-back: three writes, each setup immediately following the previous RESP, then three reads -> all data intact, each transfer taking exactly WAIT_STATES+2 cycles.
REQ-036 Reset: assert rst during the WAIT state of a write -> all outputs 0 on the next cycle, and the target register reads 0x00 afterwards.
